traffic_light_monitor: RTL and testbench

//  Passive observer on the R/G/Y outputs of the traffic light controller.

---
 rtl/traffic_light_monitor.sv | 164 ++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// Passive checker on a traffic light's {R,G,Y} outputs: reports segments and phase violations.
// Optional cycle tracker (cyc_done/cyc_cnt) is built only when TL_MON_CYCLE_EN is defined.
module traffic_light_monitor #(
    parameter int CNT_W     = 16,
    parameter int Y_CYC     = 512,
    parameter int R_CYC     = 1024,
    parameter int BLINK_CYC = 128,
    parameter int G_MIN     = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             R,
    input  logic             G,
    input  logic             Y,
    output logic             seg_vld,
    output logic [2:0]       seg_code,
    output logic [CNT_W-1:0] seg_len,
    output logic             err,
    output logic [2:0]       err_code,
    output logic [7:0]       err_cnt,
    output logic             cyc_done,
    output logic [15:0]      cyc_cnt
);

    typedef enum logic [2:0] {ST_IDLE, ST_G, ST_OFF, ST_Y, ST_R, ST_BAD} state_t;

    state_t           state_q, state_d, new_st;
    logic [2:0]       s_code_q, cur_code_q, cur_code_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             first_q, first_d;
    logic             seg_vld_q, seg_vld_d, err_q, err_d;
    logic [2:0]       seg_code_q, seg_code_d, err_code_q, err_code_d;
    logic [CNT_W-1:0] seg_len_q, seg_len_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic             change, multi, checked, legal, len_chk, any_err;
    logic             e1, e2, e3, e4, e5, e6;

    always_comb begin
        change  = (s_code_q != cur_code_q);
        multi   = (s_code_q[0] & s_code_q[1]) | (s_code_q[0] & s_code_q[2]) |
                  (s_code_q[1] & s_code_q[2]);
        case (s_code_q)
            3'b000:  new_st = ST_OFF;
            3'b001:  new_st = ST_Y;
            3'b010:  new_st = ST_G;
            3'b100:  new_st = ST_R;
            default: new_st = ST_BAD;
        endcase
        // IDLE and BAD exits are never judged; only real phases carry rules.
        checked = (state_q == ST_G) || (state_q == ST_OFF) || (state_q == ST_Y) || (state_q == ST_R);
        legal   = ((state_q == ST_G)   && ((new_st == ST_OFF) || (new_st == ST_Y))) ||
                  ((state_q == ST_OFF) && (new_st == ST_G)) ||
                  ((state_q == ST_Y)   && (new_st == ST_R)) ||
                  ((state_q == ST_R)   && (new_st == ST_G));
        len_chk = checked && !first_q;
        e1 = multi && (state_q != ST_BAD);
        e2 = checked && !legal;
        e3 = len_chk && (state_q == ST_Y)   && (len_q != CNT_W'(Y_CYC));
        e4 = len_chk && (state_q == ST_R)   && (len_q != CNT_W'(R_CYC));
        e5 = len_chk && (state_q == ST_OFF) && (len_q != CNT_W'(BLINK_CYC));
        e6 = len_chk && (state_q == ST_G)   && (len_q < CNT_W'(G_MIN));
        any_err = e1 | e2 | e3 | e4 | e5 | e6;
    end

    always_comb begin
        state_d    = state_q;
        first_d    = first_q;
        cur_code_d = cur_code_q;
        len_d      = (len_q == '1) ? len_q : len_q + 1'b1;
        seg_vld_d  = 1'b0;
        seg_code_d = seg_code_q;
        seg_len_d  = seg_len_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        err_cnt_d  = err_cnt_q;
        if (change) begin
            cur_code_d = s_code_q;
            len_d      = CNT_W'(1);
            state_d    = new_st;
            // Leaving IDLE opens the partial segment; ending it clears first.
            if (state_q != ST_IDLE) begin
                first_d = 1'b0;
                if (!first_q) begin
                    seg_vld_d  = 1'b1;
                    seg_code_d = cur_code_q;
                    seg_len_d  = len_q;
                end
            end
            if (any_err) begin
                err_d      = 1'b1;
                err_code_d = e1 ? 3'd1 : e2 ? 3'd2 : e3 ? 3'd3 :
                             e4 ? 3'd4 : e5 ? 3'd5 : 3'd6;
                err_cnt_d  = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            first_q    <= 1'b1;
            s_code_q   <= 3'b000;
            cur_code_q <= 3'b000;
            len_q      <= '0;
            seg_vld_q  <= 1'b0;
            seg_code_q <= 3'b000;
            seg_len_q  <= '0;
            err_q      <= 1'b0;
            err_code_q <= 3'b000;
            err_cnt_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            first_q    <= first_d;
            s_code_q   <= {R, G, Y};
            cur_code_q <= cur_code_d;
            len_q      <= len_d;
            seg_vld_q  <= seg_vld_d;
            seg_code_q <= seg_code_d;
            seg_len_q  <= seg_len_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign seg_vld  = seg_vld_q;
    assign seg_code = seg_code_q;
    assign seg_len  = seg_len_q;
    assign err      = err_q;
    assign err_code = err_code_q;
    assign err_cnt  = err_cnt_q;

`ifdef TL_MON_CYCLE_EN
    logic        y_from_g_q, y_ok_q, cyc_done_q;
    logic [15:0] cyc_cnt_q;
    logic        cyc_hit;

    // A Y counts only if entered cleanly from G and ended cleanly into R.
    assign cyc_hit = change && (state_q == ST_R) && !first_q && y_ok_q && !any_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_from_g_q <= 1'b0;
            y_ok_q     <= 1'b0;
            cyc_done_q <= 1'b0;
            cyc_cnt_q  <= 16'd0;
        end else begin
            cyc_done_q <= cyc_hit;
            if (cyc_hit) cyc_cnt_q <= cyc_cnt_q + 16'd1;
            if (change) begin
                y_from_g_q <= (state_q == ST_G) && (new_st == ST_Y) && !any_err;
                y_ok_q     <= (state_q == ST_Y) && y_from_g_q && !first_q && !any_err;
            end
        end
    end

    assign cyc_done = cyc_done_q;
    assign cyc_cnt  = cyc_cnt_q;
`else
    assign cyc_done = 1'b0;
    assign cyc_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: light sequences with hand-computed segment/error reports.
module tb_traffic_light_monitor;

  localparam logic [2:0] C_OFF = 3'b000, C_Y = 3'b001, C_G = 3'b010, C_R = 3'b100;
`ifdef TL_MON_CYCLE_EN
  localparam int CYC_ON = 1;
`else
  localparam int CYC_ON = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        r = 1'b0, g = 1'b0, y = 1'b0;
  logic        seg_vld, err, cyc_done;
  logic [2:0]  seg_code, err_code;
  logic [15:0] seg_len, cyc_cnt;
  logic [7:0]  err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [18:0] exp_q[$];
  logic [18:0] seg_obs_q[$];
  logic [3:0]  exp_err_q[$];
  logic [3:0]  err_obs_q[$];

  traffic_light_monitor dut (
    .clk(clk), .rst_n(rst_n), .R(r), .G(g), .Y(y),
    .seg_vld(seg_vld), .seg_code(seg_code), .seg_len(seg_len),
    .err(err), .err_code(err_code), .err_cnt(err_cnt),
    .cyc_done(cyc_done), .cyc_cnt(cyc_cnt)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // observed events: segments as {code,len}, errors as {seg_vld,err_code}
  always @(negedge clk) begin
    if (seg_vld) seg_obs_q.push_back({seg_code, seg_len});
    if (err) err_obs_q.push_back({seg_vld, err_code});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic [2:0] c, input int n);
    {r, g, y} = c;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    {r, g, y} = C_OFF;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seg_obs_q.delete();
    err_obs_q.delete();
  endtask

  task automatic check_scoreboard(input string tag);
    #1;
    chk({tag, "_nseg"}, seg_obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && seg_obs_q.size() > 0)
      chk({tag, "_seg"}, seg_obs_q.pop_front(), exp_q.pop_front());
    chk({tag, "_nerr"}, err_obs_q.size(), exp_err_q.size());
    while (exp_err_q.size() > 0 && err_obs_q.size() > 0)
      chk({tag, "_err"}, err_obs_q.pop_front(), exp_err_q.pop_front());
    exp_q.delete(); seg_obs_q.delete(); exp_err_q.delete(); err_obs_q.delete();
  endtask

  initial begin
    // reset values
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_seg_vld", seg_vld, 0);
    chk("rst_seg_code", seg_code, 0);
    chk("rst_seg_len", seg_len, 0);
    chk("rst_err", err, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_cyc_done", cyc_done, 0);
    chk("rst_cyc_cnt", cyc_cnt, 0);

    // 1: partial R, then a full legal cycle
    do_reset();
    hold(C_R, 1024); hold(C_G, 1024); hold(C_Y, 512); hold(C_R, 1024); hold(C_G, 10);
    exp_q.push_back({C_G, 16'd1024});
    exp_q.push_back({C_Y, 16'd512});
    exp_q.push_back({C_R, 16'd1024});
    check_scoreboard("t1");
    chk("t1_err_cnt", err_cnt, 0);
    chk("t1_cyc_cnt", cyc_cnt, CYC_ON);

    // 2: blink gaps inside a legal cycle
    do_reset();
    hold(C_R, 10); hold(C_G, 1024); hold(C_OFF, 128); hold(C_G, 128); hold(C_OFF, 128);
    hold(C_G, 128); hold(C_Y, 512); hold(C_R, 1024); hold(C_G, 10);
    exp_q.push_back({C_G, 16'd1024});
    exp_q.push_back({C_OFF, 16'd128});
    exp_q.push_back({C_G, 16'd128});
    exp_q.push_back({C_OFF, 16'd128});
    exp_q.push_back({C_G, 16'd128});
    exp_q.push_back({C_Y, 16'd512});
    exp_q.push_back({C_R, 16'd1024});
    check_scoreboard("t2");
    chk("t2_err_cnt", err_cnt, 0);
    chk("t2_cyc_cnt", cyc_cnt, CYC_ON);

    // 3: yellow one cycle short
    do_reset();
    hold(C_G, 10); hold(C_Y, 511); hold(C_R, 1024); hold(C_G, 10);
    exp_q.push_back({C_Y, 16'd511});
    exp_q.push_back({C_R, 16'd1024});
    exp_err_q.push_back({1'b1, 3'd3});
    check_scoreboard("t3");
    chk("t3_err_cnt", err_cnt, 1);
    chk("t3_err_code", err_code, 3);
    chk("t3_cyc_cnt", cyc_cnt, 0);

    // 4: green straight to red
    do_reset();
    hold(C_R, 10); hold(C_G, 200); hold(C_R, 1024); hold(C_G, 10);
    exp_q.push_back({C_G, 16'd200});
    exp_q.push_back({C_R, 16'd1024});
    exp_err_q.push_back({1'b1, 3'd2});
    check_scoreboard("t4");
    chk("t4_err_cnt", err_cnt, 1);
    chk("t4_cyc_cnt", cyc_cnt, 0);

    // 5: multi-hot burst, then a clean cycle after BAD
    do_reset();
    hold(C_R, 10); hold(C_G, 200); hold(3'b110, 5); hold(C_G, 200); hold(C_Y, 512);
    hold(C_R, 1024); hold(C_G, 10);
    exp_q.push_back({C_G, 16'd200});
    exp_q.push_back({3'b110, 16'd5});
    exp_q.push_back({C_G, 16'd200});
    exp_q.push_back({C_Y, 16'd512});
    exp_q.push_back({C_R, 16'd1024});
    exp_err_q.push_back({1'b1, 3'd1});
    check_scoreboard("t5");
    chk("t5_err_cnt", err_cnt, 1);
    chk("t5_cyc_cnt", cyc_cnt, CYC_ON);

    // 6: short green error, then asynchronous reset mid-yellow
    do_reset();
    hold(C_R, 10); hold(C_G, 50); hold(C_Y, 100);
    exp_q.push_back({C_G, 16'd50});
    exp_err_q.push_back({1'b1, 3'd6});
    check_scoreboard("t6a");
    chk("t6_pre_err_cnt", err_cnt, 1);
    chk("t6_pre_err_code", err_code, 6);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_err_cnt", err_cnt, 0);
    chk("t6_async_err_code", err_code, 0);
    chk("t6_async_seg_len", seg_len, 0);
    chk("t6_async_seg_code", seg_code, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hold(C_Y, 400); hold(C_R, 1024); hold(C_G, 10);
    exp_q.push_back({C_R, 16'd1024});
    check_scoreboard("t6b");
    chk("t6_err_cnt", err_cnt, 0);
    chk("t6_cyc_cnt", cyc_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
